chip8_fetch_decode: RTL and testbench
=====================================

// Module: chip8_fetch_decode
// PURPOSE
//  Front-end stage of the CHIP-8 core: owns the program counter and fetches each 2-byte big-endian opcode from byte-wide program memory.
//  Decodes it into the 6-bit operation code and operand fields the execute stage consumes, and presents them through a valid/ready handshake.
//  Accepts PC redirects (JMP/CALL/RET/skip) from execute.
// PARAMETERS
//  RESET_PC   12'h200  PC value loaded on reset
//  ADDR_W     12       program memory byte-address width
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, synchronous, active-high
//  mem_rd_en    out  1       memory read strobe; data is returned one cycle later
//  mem_rd_addr  out  ADDR_W  byte address of the read
//  mem_rd_data  in   8       read data, valid the cycle after mem_rd_en
//  redirect_en  in   1       load PC from redirect_pc and abort any fetch in flight
//  redirect_pc  in   ADDR_W  new PC, byte address
//  issue_valid  out  1       decoded instruction is available
//  issue_ready  in   1       execute accepts it this cycle
//  decode       out  6       operation code: 0 = NOP/unknown, 1..35 per the package table
//  x            out  4       opcode[11:8]; forced to 0 for Bnnn so execute reads V0
//  y            out  4       opcode[7:4]
//  val          out  8       opcode[7:0] (kk; n is val[3:0])
//  addr         out  12      opcode[11:0] (nnn)
//  pc_out       out  ADDR_W  address of the next sequential instruction (instr PC+2), used as the CALL return address
//  illegal      out  1       unknown opcode trapped (CHIP8_ILLEGAL_TRAP_EN only; otherwise tied 0)
// BEHAVIOUR
//  Reset:
//   - pc = RESET_PC, state = FETCH_HI.
//   - All outputs 0, except mem_rd_addr = RESET_PC.
//  FSM:
//   - FETCH_HI: mem_rd_en=1, addr=pc -> FETCH_LO.
//   - FETCH_LO: capture hi byte; mem_rd_en=1, addr=pc+1 -> DECODE.
//   - DECODE: capture lo byte; register decode/x/y/val/addr/pc_out -> ISSUE.
//   - ISSUE: issue_valid=1; outputs held stable while issue_ready=0.
//   - On issue_valid & issue_ready: pc <= pc+2 -> FETCH_HI.
//  Timing: minimum 4 cycles per instruction. Successive issues are at least 3 cycles apart, so register writes from execute land before the next operand read; no hazard logic is needed.
//  Redirect:
//   - redirect_en has priority in every state, including over the issue handshake in the same cycle.
//   - Effect: pc <= redirect_pc, state <= FETCH_HI, issue_valid drops next cycle.
//   - The in-flight read is discarded.
//   - If issue_valid & issue_ready coincide with redirect_en, the instruction counts as issued and the PC still takes redirect_pc.
//  Arithmetic:
//   - pc+1 and pc+2 are mod 2^ADDR_W (0xFFF+1 -> 0x000).
//   - Odd PCs are legal and fetched as given.
//  Decode table:
//   - 00E0=1, 00EE=2, 1nnn=3, 2nnn=4, 3xkk=5, 4xkk=6, 5xy0=7, 6xkk=8, 7xkk=9.
//   - 8xy0..8xy7=10..17, 8xyE=18, 9xy0=19, Annn=20, Bnnn=21, Cxkk=22, Dxyn=23.
//   - Ex9E=24, ExA1=25, Fx07=26, Fx0A=27, Fx15=28, Fx18=29, Fx1E=30, Fx29=32, Fx33=33, Fx55=34, Fx65=35.
//   - Any other encoding, including 0nnn SYS, is unknown.
//  Reset mid-fetch: state and PC return to reset values next cycle; partial opcode is dropped.
// CONFIGURATION
//  CHIP8_ILLEGAL_TRAP_EN defined:
//   - An unknown opcode in DECODE sets illegal=1 and enters the HALT state.
//   - In HALT: no reads, issue_valid=0; exit only via rst or redirect_en (which also clears illegal).
//  Undefined: an unknown opcode is issued as decode=0 (NOP) and fetching continues; illegal is tied 0.
// STRUCTURE
//  Shared package chip8_pkg:
//   - Decode localparams (DISP_CLR..READ_REG_VX, values above) so execute and this block share them.
//   - STACK_OFFSET, RESET_PC default.
//  Sub-module chip8_opcode_decoder: combinational, 16-bit opcode -> {decode, unknown}.
//  This block holds the FSM, PC and opcode/output registers.
// TESTING
//  - Reset; mem[200]=6A, mem[201]=2F -> reads at 200, 201; issue decode=8, x=A, val=2F, pc_out=202; after ready, next read at 202.
//  - issue_ready low 5 cycles on 8125 -> issue_valid held, decode=15, x=1, y=2 stable; no memory reads until accepted.
//  - redirect_en with redirect_pc=3A0 during FETCH_LO -> next mem_rd_addr=3A0; the stale lo byte is never issued.
//  - Opcode B123 -> decode=21, x=0, addr=123; opcode 00EE -> decode=2; F933 -> decode=33, x=9.
//  - Redirect to FFF with mem[FFF]=A2, mem[000]=50 -> reads FFF then 000; decode=20, addr=250, pc_out=001.
//  - Opcode 5121:
//     - with CHIP8_ILLEGAL_TRAP_EN -> illegal=1, issue_valid stays 0, no reads until redirect.
//     - without it -> decode=0 issued, next read at pc+2.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: operation codes used by fetch/decode and execute,
// reset/stack constants and the front-end FSM state type.
package chip8_pkg;

  localparam logic [11:0] RESET_PC_DEFAULT = 12'h200;
  localparam logic [11:0] STACK_OFFSET     = 12'hEA0;

  // Operation codes presented on the decode output (0 = NOP / unknown).
  localparam logic [5:0] OP_NOP        = 6'd0;
  localparam logic [5:0] DISP_CLR      = 6'd1;   // 00E0
  localparam logic [5:0] RET           = 6'd2;   // 00EE
  localparam logic [5:0] JMP           = 6'd3;   // 1nnn
  localparam logic [5:0] CALL          = 6'd4;   // 2nnn
  localparam logic [5:0] SKIP_EQ_VX_KK = 6'd5;   // 3xkk
  localparam logic [5:0] SKIP_NE_VX_KK = 6'd6;   // 4xkk
  localparam logic [5:0] SKIP_EQ_VX_VY = 6'd7;   // 5xy0
  localparam logic [5:0] LD_VX_KK      = 6'd8;   // 6xkk
  localparam logic [5:0] ADD_VX_KK     = 6'd9;   // 7xkk
  localparam logic [5:0] LD_VX_VY      = 6'd10;  // 8xy0
  localparam logic [5:0] OR_VX_VY      = 6'd11;  // 8xy1
  localparam logic [5:0] AND_VX_VY     = 6'd12;  // 8xy2
  localparam logic [5:0] XOR_VX_VY     = 6'd13;  // 8xy3
  localparam logic [5:0] ADD_VX_VY     = 6'd14;  // 8xy4
  localparam logic [5:0] SUB_VX_VY     = 6'd15;  // 8xy5
  localparam logic [5:0] SHR_VX        = 6'd16;  // 8xy6
  localparam logic [5:0] SUBN_VX_VY    = 6'd17;  // 8xy7
  localparam logic [5:0] SHL_VX        = 6'd18;  // 8xyE
  localparam logic [5:0] SKIP_NE_VX_VY = 6'd19;  // 9xy0
  localparam logic [5:0] LD_I          = 6'd20;  // Annn
  localparam logic [5:0] JMP_V0        = 6'd21;  // Bnnn
  localparam logic [5:0] RND_VX        = 6'd22;  // Cxkk
  localparam logic [5:0] DRAW          = 6'd23;  // Dxyn
  localparam logic [5:0] SKIP_KEY      = 6'd24;  // Ex9E
  localparam logic [5:0] SKIP_NKEY     = 6'd25;  // ExA1
  localparam logic [5:0] LD_VX_DT      = 6'd26;  // Fx07
  localparam logic [5:0] WAIT_KEY      = 6'd27;  // Fx0A
  localparam logic [5:0] LD_DT_VX      = 6'd28;  // Fx15
  localparam logic [5:0] LD_ST_VX      = 6'd29;  // Fx18
  localparam logic [5:0] ADD_I_VX      = 6'd30;  // Fx1E
  localparam logic [5:0] LD_FONT       = 6'd32;  // Fx29
  localparam logic [5:0] BCD_VX        = 6'd33;  // Fx33
  localparam logic [5:0] STORE_REG_VX  = 6'd34;  // Fx55
  localparam logic [5:0] READ_REG_VX   = 6'd35;  // Fx65

  typedef enum logic [2:0] {
    FETCH_HI = 3'd0,
    FETCH_LO = 3'd1,
    DECODE   = 3'd2,
    ISSUE    = 3'd3,
    HALT     = 3'd4
  } fd_state_t;

endpackage

// File: rtl/chip8_fetch_decode_if.sv
// Bus bundle between the fetch/decode front end, program memory and execute.
// master = fetch/decode side, slave = memory + execute side.
interface chip8_fetch_decode_if #(
  parameter int ADDR_W = 12
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [7:0]        mem_rd_data;
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_pc;
  logic              issue_valid;
  logic              issue_ready;
  logic [5:0]        decode;
  logic [3:0]        x;
  logic [3:0]        y;
  logic [7:0]        val;
  logic [11:0]       addr;
  logic [ADDR_W-1:0] pc_out;
  logic              illegal;

  modport master (
    output mem_rd_en, mem_rd_addr, issue_valid, decode, x, y, val, addr,
           pc_out, illegal,
    input  mem_rd_data, redirect_en, redirect_pc, issue_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, issue_valid, decode, x, y, val, addr,
           pc_out, illegal,
    output mem_rd_data, redirect_en, redirect_pc, issue_ready
  );
endinterface

// File: rtl/chip8_opcode_decoder.sv
// Combinational CHIP-8 opcode classifier: 16-bit opcode -> operation code.
// Anything not in the table (including 0nnn SYS) maps to OP_NOP + unknown.
module chip8_opcode_decoder
  import chip8_pkg::*;
(
  input  logic [15:0] opcode,
  output logic [5:0]  decode,
  output logic        unknown
);

  // Table lookup on the top nibble, refined by the low nibble/byte.
  always_comb begin
    decode = OP_NOP;
    case (opcode[15:12])
      4'h0: begin
        if (opcode == 16'h00E0)      decode = DISP_CLR;
        else if (opcode == 16'h00EE) decode = RET;
      end
      4'h1: decode = JMP;
      4'h2: decode = CALL;
      4'h3: decode = SKIP_EQ_VX_KK;
      4'h4: decode = SKIP_NE_VX_KK;
      4'h5: if (opcode[3:0] == 4'h0) decode = SKIP_EQ_VX_VY;
      4'h6: decode = LD_VX_KK;
      4'h7: decode = ADD_VX_KK;
      4'h8: begin
        case (opcode[3:0])
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7:
            decode = LD_VX_VY + {3'b000, opcode[2:0]};
          4'hE:    decode = SHL_VX;
          default: decode = OP_NOP;
        endcase
      end
      4'h9: if (opcode[3:0] == 4'h0) decode = SKIP_NE_VX_VY;
      4'hA: decode = LD_I;
      4'hB: decode = JMP_V0;
      4'hC: decode = RND_VX;
      4'hD: decode = DRAW;
      4'hE: begin
        case (opcode[7:0])
          8'h9E:   decode = SKIP_KEY;
          8'hA1:   decode = SKIP_NKEY;
          default: decode = OP_NOP;
        endcase
      end
      4'hF: begin
        case (opcode[7:0])
          8'h07:   decode = LD_VX_DT;
          8'h0A:   decode = WAIT_KEY;
          8'h15:   decode = LD_DT_VX;
          8'h18:   decode = LD_ST_VX;
          8'h1E:   decode = ADD_I_VX;
          8'h29:   decode = LD_FONT;
          8'h33:   decode = BCD_VX;
          8'h55:   decode = STORE_REG_VX;
          8'h65:   decode = READ_REG_VX;
          default: decode = OP_NOP;
        endcase
      end
      default: decode = OP_NOP;
    endcase
  end

  assign unknown = (decode == OP_NOP);

endmodule

// File: rtl/chip8_fetch_decode.sv
// CHIP-8 front end: program counter, 2-byte big-endian opcode fetch from
// byte-wide memory (1-cycle read latency), decode and valid/ready issue.
// Optional feature macro: CHIP8_ILLEGAL_TRAP_EN -- when defined, unknown
// opcodes raise illegal and park the FSM in HALT until a redirect or reset.
module chip8_fetch_decode
  import chip8_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  chip8_fetch_decode_if.master bus
);

  fd_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [7:0]        hi_reg;
  logic [5:0]        decode_reg;
  logic [3:0]        x_reg, y_reg;
  logic [7:0]        val_reg;
  logic [11:0]       addr_reg;
  logic [ADDR_W-1:0] pc_out_reg;

  logic              rd_en_next;
  logic [ADDR_W-1:0] rd_addr_next;
  logic [15:0]       opcode;
  logic [5:0]        dec_op;
  logic              dec_unknown;

  // The low byte arrives on mem_rd_data during DECODE; the high byte was
  // captured one cycle earlier.
  assign opcode = {hi_reg, bus.mem_rd_data};

  chip8_opcode_decoder u_decoder (
    .opcode  (opcode),
    .decode  (dec_op),
    .unknown (dec_unknown)
  );

  // Next-state and memory strobe; redirect overrides every state.
  always_comb begin
    state_next   = state_reg;
    rd_en_next   = 1'b0;
    rd_addr_next = pc_reg;
    case (state_reg)
      FETCH_HI: begin
        rd_en_next = 1'b1;
        state_next = FETCH_LO;
      end
      FETCH_LO: begin
        rd_en_next   = 1'b1;
        rd_addr_next = pc_reg + ADDR_W'(1);
        state_next   = DECODE;
      end
      DECODE: begin
`ifdef CHIP8_ILLEGAL_TRAP_EN
        state_next = dec_unknown ? HALT : ISSUE;
`else
        state_next = ISSUE;
`endif
      end
      ISSUE: begin
        if (bus.issue_ready) state_next = FETCH_HI;
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH_HI;
    endcase
    if (bus.redirect_en) state_next = FETCH_HI;
  end

  // State, PC and decoded-field registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= FETCH_HI;
      pc_reg     <= RESET_PC;
      hi_reg     <= 8'h00;
      decode_reg <= OP_NOP;
      x_reg      <= 4'h0;
      y_reg      <= 4'h0;
      val_reg    <= 8'h00;
      addr_reg   <= 12'h000;
      pc_out_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == FETCH_LO) hi_reg <= bus.mem_rd_data;
      if (state_reg == DECODE && !bus.redirect_en) begin
        decode_reg <= dec_op;
        // Bnnn jumps relative to V0, so execute reads register 0.
        x_reg      <= (dec_op == JMP_V0) ? 4'h0 : opcode[11:8];
        y_reg      <= opcode[7:4];
        val_reg    <= opcode[7:0];
        addr_reg   <= opcode[11:0];
        pc_out_reg <= pc_reg + ADDR_W'(2);
      end
      if (bus.redirect_en)
        pc_reg <= bus.redirect_pc;
      else if (state_reg == ISSUE && bus.issue_ready)
        pc_reg <= pc_reg + ADDR_W'(2);
    end
  end

`ifdef CHIP8_ILLEGAL_TRAP_EN
  logic illegal_reg;

  // Sticky trap flag; only a redirect (or reset) clears it.
  always_ff @(posedge clk) begin
    if (rst)
      illegal_reg <= 1'b0;
    else if (bus.redirect_en)
      illegal_reg <= 1'b0;
    else if (state_reg == DECODE && dec_unknown)
      illegal_reg <= 1'b1;
  end

  assign bus.illegal = illegal_reg;
`else
  assign bus.illegal = 1'b0;
`endif

  // Strobes are masked while reset is held so the bus is quiet in reset.
  assign bus.mem_rd_en   = rd_en_next & ~rst;
  assign bus.mem_rd_addr = rd_addr_next;
  assign bus.issue_valid = (state_reg == ISSUE) & ~rst;
  assign bus.decode      = decode_reg;
  assign bus.x           = x_reg;
  assign bus.y           = y_reg;
  assign bus.val         = val_reg;
  assign bus.addr        = addr_reg;
  assign bus.pc_out      = pc_out_reg;

endmodule

// File: tb/tb_chip8_fetch_decode.sv
// Directed bench for chip8_fetch_decode with a 1-cycle-latency memory model.
module tb_chip8_fetch_decode;
  import chip8_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chip8_fetch_decode_if #(.ADDR_W(12)) bus ();

  chip8_fetch_decode #(.ADDR_W(12), .RESET_PC(12'h200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:4095];
  logic [7:0] rd_q;

  // Program memory: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_rd_en) rd_q <= mem[bus.mem_rd_addr];
  end
  assign bus.mem_rd_data = rd_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_read(input string tag, input logic [31:0] a);
    check({tag, "_en"}, 32'(bus.mem_rd_en), 1);
    check({tag, "_addr"}, 32'(bus.mem_rd_addr), a);
  endtask

  task automatic wait_issue(input string tag);
    for (int i = 0; i < 20 && !bus.issue_valid; i++) tick();
    check({tag, "_valid"}, 32'(bus.issue_valid), 1);
  endtask

  task automatic expect_issue(input string tag, input logic [31:0] dec, input logic [31:0] ex,
                              input logic [31:0] ey, input logic [31:0] ev,
                              input logic [31:0] ea, input logic [31:0] epc);
    wait_issue(tag);
    check({tag, "_decode"}, 32'(bus.decode), dec);
    check({tag, "_x"}, 32'(bus.x), ex);
    check({tag, "_y"}, 32'(bus.y), ey);
    check({tag, "_val"}, 32'(bus.val), ev);
    check({tag, "_addr"}, 32'(bus.addr), ea);
    check({tag, "_pc_out"}, 32'(bus.pc_out), epc);
  endtask

  task automatic accept();
    $display("issue accepted: decode=%0d x=%0h y=%0h val=%02h addr=%03h pc_out=%03h",
             bus.decode, bus.x, bus.y, bus.val, bus.addr, bus.pc_out);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'h6A; mem[12'h201] = 8'h2F;
    mem[12'h202] = 8'h81; mem[12'h203] = 8'h25;
    mem[12'h204] = 8'hB1; mem[12'h205] = 8'h23;
    mem[12'h206] = 8'h00; mem[12'h207] = 8'hEE;
    mem[12'h208] = 8'hF9; mem[12'h209] = 8'h33;
    mem[12'h20A] = 8'h51; mem[12'h20B] = 8'h21;
    mem[12'h20C] = 8'h12; mem[12'h20D] = 8'h34;
    mem[12'h3A0] = 8'h63; mem[12'h3A1] = 8'h07;
    mem[12'hFFF] = 8'hA2; mem[12'h000] = 8'h50;

    rst = 1'b1;
    bus.issue_ready = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 12'h000;
    tick();
    tick();
    check("rst_rd_en", 32'(bus.mem_rd_en), 0);
    check("rst_rd_addr", 32'(bus.mem_rd_addr), 'h200);
    check("rst_valid", 32'(bus.issue_valid), 0);
    check("rst_decode", 32'(bus.decode), 0);
    check("rst_pc_out", 32'(bus.pc_out), 0);
    check("rst_illegal", 32'(bus.illegal), 0);

    // First instruction 6A2F: LD VA,2F.
    rst = 1'b0;
    #1;
    expect_read("rd_200", 'h200);
    tick();
    expect_read("rd_201", 'h201);
    tick();
    check("decode_no_rd", 32'(bus.mem_rd_en), 0);
    expect_issue("ld_6a2f", 8, 'hA, 'h2, 'h2F, 'hA2F, 'h202);
    accept();
    expect_read("rd_202", 'h202);

    // 8125 held by back-pressure for 5 cycles.
    wait_issue("sub_8125");
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", 32'(bus.issue_valid), 1);
      check("hold_decode", 32'(bus.decode), 15);
      check("hold_x", 32'(bus.x), 1);
      check("hold_y", 32'(bus.y), 2);
      check("hold_no_rd", 32'(bus.mem_rd_en), 0);
      tick();
    end
    accept();
    expect_read("rd_204", 'h204);

    expect_issue("jmpv0_b123", 21, 0, 2, 'h23, 'h123, 'h206);
    accept();
    expect_issue("ret_00ee", 2, 0, 'hE, 'hEE, 'h0EE, 'h208);
    accept();
    expect_issue("bcd_f933", 33, 9, 3, 'h33, 'h933, 'h20A);
    accept();

    // 5121 is not a valid 5xy0 encoding.
`ifdef CHIP8_ILLEGAL_TRAP_EN
    tick();
    tick();
    tick();
    check("trap_illegal", 32'(bus.illegal), 1);
    for (int k = 0; k < 3; k++) begin
      check("trap_no_valid", 32'(bus.issue_valid), 0);
      check("trap_no_rd", 32'(bus.mem_rd_en), 0);
      tick();
    end
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 12'h20C;
    tick();
    bus.redirect_en = 1'b0;
    check("trap_cleared", 32'(bus.illegal), 0);
    expect_read("rd_trap_20c", 'h20C);
`else
    expect_issue("nop_5121", 0, 1, 2, 'h21, 'h121, 'h20C);
    check("nop_illegal", 32'(bus.illegal), 0);
    accept();
    expect_read("rd_20c", 'h20C);
`endif

    // Redirect during FETCH_LO: the 12xx hi byte must never be issued.
    tick();
    expect_read("rd_20d", 'h20D);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 12'h3A0;
    tick();
    bus.redirect_en = 1'b0;
    expect_read("rd_3a0", 'h3A0);
    expect_issue("ld_6307", 8, 3, 0, 'h07, 'h307, 'h3A2);
    accept();

    // Redirect to the top of memory: lo byte wraps to address 000.
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 12'hFFF;
    tick();
    bus.redirect_en = 1'b0;
    expect_read("rd_fff", 'hFFF);
    tick();
    expect_read("rd_wrap_000", 'h000);
    expect_issue("ldi_a250", 20, 2, 5, 'h50, 'h250, 'h001);

    // Handshake and redirect in the same cycle: redirect PC wins.
    bus.issue_ready = 1'b1;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 12'h200;
    tick();
    bus.issue_ready = 1'b0;
    bus.redirect_en = 1'b0;
    check("coinc_valid", 32'(bus.issue_valid), 0);
    expect_read("coinc_rd_200", 'h200);

    // Reset in the middle of a fetch.
    tick();
    expect_read("mid_rd_201", 'h201);
    rst = 1'b1;
    tick();
    check("midrst_rd_en", 32'(bus.mem_rd_en), 0);
    check("midrst_rd_addr", 32'(bus.mem_rd_addr), 'h200);
    rst = 1'b0;
    #1;
    expect_read("post_rst_200", 'h200);
    expect_issue("post_rst_6a2f", 8, 'hA, 'h2, 'h2F, 'hA2F, 'h202);
    accept();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
